// File: rtl/nco_pkg.sv
// Shared constants, FSM state encoding and sample record for the NCO phase
// deserializer and its output buffer.
package nco_pkg;

    localparam int DIGITS  = 6;
    localparam int DIGIT_W = 2;
    localparam int ANGLE_W = DIGITS * DIGIT_W;
    localparam int CNT_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ANGLE_W-1:0] angle;
        logic               sign;
        logic               ang_err;
    } sample_t;

    // A folded angle must have matching top two bits; 01 or 10 is out of range.
    function automatic logic fold_err(input logic [ANGLE_W-1:0] a);
        return a[ANGLE_W-1] ^ a[ANGLE_W-2];
    endfunction

endpackage

// File: rtl/nco_sample_fifo.sv
// Two-entry synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module nco_sample_fifo
    import nco_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nco_phase_deserializer.sv
// Frames the serial 2-bit phase digit stream into 12-bit folded angle samples
// and buffers them for the downstream sine stage.
//
//   state | meaning
//   IDLE  | waiting for a Vld strobe; Ain ignored
//   SHIFT | capturing digit cnt of the current frame, LSB digit first
module nco_phase_deserializer
    import nco_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Vld,
    input  logic [DIGIT_W-1:0] Ain,
    input  logic               ISin,
    input  logic               ovr_clr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [ANGLE_W-1:0] out_angle,
    output logic               out_sign,
    output logic               ang_err,
    output logic               frm_err,
    output logic               ovr
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ANGLE_W-1:0] shreg_q, shreg_d;
    logic               sign_q, sign_d;
    logic               frm_err_d;
    logic               push;
    sample_t            push_sample;
    sample_t            head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sign_q  <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sign_q  <= sign_d;
            frm_err <= frm_err_d;
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        sign_d    = sign_q;
        frm_err_d = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Vld) begin
                    sign_d  = ISin;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (Vld) begin
                    // Truncated frame: drop the partial capture and restart.
                    frm_err_d = 1'b1;
                    sign_d    = ISin;
                    shreg_d   = '0;
                    cnt_d     = '0;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shreg_d[i*DIGIT_W +: DIGIT_W] = Ain;
                        end
                    end
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        push_sample.angle   = shreg_d;
        push_sample.sign    = sign_q;
        push_sample.ang_err = fold_err(shreg_d);
    end

    // A full buffer only overruns if the head is not leaving this same cycle.
    assign ovr_set = push && fifo_full && !(out_ready && !fifo_empty);

    nco_sample_fifo #(
        .WIDTH ($bits(sample_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_sample),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_angle = head.angle;
    assign out_sign  = head.sign;
    assign ang_err   = head.ang_err;

endmodule

// File: tb/tb_nco_phase_deserializer.sv
// Directed bench for nco_phase_deserializer with a queue-based scoreboard of
// expected output samples and a model of buffer occupancy and overrun.
module tb_nco_phase_deserializer;
    import nco_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               Vld;
    logic [DIGIT_W-1:0] Ain;
    logic               ISin;
    logic               ovr_clr;
    logic               out_ready;
    logic               out_valid;
    logic [ANGLE_W-1:0] out_angle;
    logic               out_sign;
    logic               ang_err;
    logic               frm_err;
    logic               ovr;

    int      vectors     = 0;
    int      miscompares = 0;
    sample_t exp_q[$];
    bit      exp_ovr     = 0;
    bit      frm_exp     = 0;
    bit      pend_valid  = 0;
    sample_t pend_s;

    nco_phase_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Vld       (Vld),
        .Ain       (Ain),
        .ISin      (ISin),
        .ovr_clr   (ovr_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_angle (out_angle),
        .out_sign  (out_sign),
        .ang_err   (ang_err),
        .frm_err   (frm_err),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: pop/push bookkeeping before the edge, registered flags after it.
    task automatic tick();
        int      sz;
        bit      pop;
        bit      nset;
        sample_t s;
        sz   = exp_q.size();
        pop  = out_ready && (sz != 0);
        nset = 0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
        if (pop) begin
            s = exp_q.pop_front();
            chk("out_angle", {20'd0, out_angle}, {20'd0, s.angle});
            chk("out_sign", {31'd0, out_sign}, {31'd0, s.sign});
            chk("ang_err", {31'd0, ang_err}, {31'd0, s.ang_err});
        end
        if (pend_valid) begin
            if (sz < 2 || pop) exp_q.push_back(pend_s);
            else nset = 1;
            pend_valid = 0;
        end
        if (nset) exp_ovr = 1;
        else if (ovr_clr) exp_ovr = 0;
        @(posedge clk);
        #1;
        chk("frm_err", {31'd0, frm_err}, {31'd0, frm_exp});
        chk("ovr", {31'd0, ovr}, {31'd0, exp_ovr});
        frm_exp = 0;
    endtask

    task automatic send_frame(input logic [ANGLE_W-1:0] ang, input logic sgn,
                              input bit trunc, input bit rdy_last);
        Vld  = 1'b1;
        ISin = sgn;
        Ain  = 2'($urandom);
        if (trunc) frm_exp = 1;
        tick();
        Vld  = 1'b0;
        ISin = ~sgn;
        for (int i = 0; i < DIGITS; i++) begin
            Ain = ang[2*i +: 2];
            if (i == DIGITS - 1) begin
                pend_valid     = 1;
                pend_s.angle   = ang;
                pend_s.sign    = sgn;
                pend_s.ang_err = ang[11] ^ ang[10];
                if (rdy_last) out_ready = 1'b1;
            end
            tick();
        end
        if (rdy_last) out_ready = 1'b0;
    endtask

    task automatic partial_frame(input int n);
        Vld  = 1'b1;
        ISin = 1'($urandom);
        tick();
        Vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            Ain = 2'($urandom);
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        Vld       = 1'b0;
        Ain       = '0;
        ISin      = 1'b0;
        ovr_clr   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_angle", {20'd0, out_angle}, 32'd0);
        chk("rst_sign", {31'd0, out_sign}, 32'd0);
        chk("rst_angerr", {31'd0, ang_err}, 32'd0);
        chk("rst_frmerr", {31'd0, frm_err}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal: digits 3,2,1,0,3,0 LSB first, sign 1
        send_frame(12'h31B, 1'b1, 0, 0);
        chk("nom_lat", {31'd0, out_valid}, 32'd1);
        chk("nom_angle", {20'd0, out_angle}, 32'h31B);
        chk("nom_sign", {31'd0, out_sign}, 32'd1);
        tick();
        chk("nom_popped", {31'd0, out_valid}, 32'd0);
        tick();

        // Back-to-back at minimum period, including both illegal-fold patterns
        send_frame(12'h3FF, 1'b0, 0, 0);
        chk("b2b_lat0", {31'd0, out_valid}, 32'd1);
        send_frame(12'hC00, 1'b1, 0, 0);
        chk("b2b_lat1", {31'd0, out_valid}, 32'd1);
        send_frame(12'h4AA, 1'b0, 0, 0);
        chk("fold01_err", {31'd0, ang_err}, 32'd1);
        send_frame(12'h8F0, 1'b1, 0, 0);
        chk("fold10_err", {31'd0, ang_err}, 32'd1);
        tick();
        tick();

        // Truncated frame followed by a full one
        partial_frame(3);
        send_frame(12'h155, 1'b0, 1, 0);
        chk("trunc_lat", {31'd0, out_valid}, 32'd1);
        chk("trunc_angle", {20'd0, out_angle}, 32'h155);
        repeat (3) tick();

        // Overrun: third frame dropped while stalled
        out_ready = 1'b0;
        send_frame(12'h0A1, 1'b0, 0, 0);
        send_frame(12'h0B2, 1'b1, 0, 0);
        send_frame(12'h0C3, 1'b0, 0, 0);
        chk("ovr_set", {31'd0, ovr}, 32'd1);
        chk("ovr_head", {20'd0, out_angle}, 32'h0A1);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();
        chk("ovr_drained", {31'd0, out_valid}, 32'd0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", {31'd0, ovr}, 32'd0);

        // Full buffer with pop in the completing cycle: no overrun
        out_ready = 1'b0;
        send_frame(12'h011, 1'b1, 0, 0);
        send_frame(12'h022, 1'b0, 0, 0);
        send_frame(12'h033, 1'b1, 0, 1);
        chk("fullpop_ovr", {31'd0, ovr}, 32'd0);
        chk("fullpop_head", {20'd0, out_angle}, 32'h022);
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-frame with a sample pending in the buffer
        out_ready = 1'b0;
        send_frame(12'h7E5, 1'b1, 0, 0);
        partial_frame(3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovr    = 0;
        pend_valid = 0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_angle", {20'd0, out_angle}, 32'd0);
        chk("mrst_sign", {31'd0, out_sign}, 32'd0);
        chk("mrst_angerr", {31'd0, ang_err}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send_frame(12'h3C9, 1'b1, 0, 0);
        chk("mrst_lat", {31'd0, out_valid}, 32'd1);
        chk("mrst_angle2", {20'd0, out_angle}, 32'h3C9);
        repeat (2) tick();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
